// File: rtl/soc_bus_responder.sv
// soc_bus_responder
//   Target side of the core's single-cycle SoC bus. Each access is decoded to
//   the on-chip data SRAM, an 8-register MMIO block that runs the accelerator
//   launch handshake, or unmapped space. Reads are combinational (zero wait
//   states); writes commit on the rising clock edge.
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   bus_valid, bus_write            access request and direction
//   bus_addr, bus_wdata, bus_rdata  word address, write data, read data (comb)
//   acc_start                       one-cycle launch pulse (from state register)
//   acc_cfg                         CFG register contents
//   acc_done, acc_result            accelerator completion pulse and result
//   irq                             registered done_sticky & irq_en
module soc_bus_responder #(
    parameter int          ADDR_W    = 19,
    parameter int          DATA_W    = 19,
    parameter int          MEM_DEPTH = 1024,
    parameter logic [18:0] MMIO_BASE = 19'h7FF00,
    parameter logic [18:0] ID_VALUE  = 19'h50C01
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_valid,
    input  logic              bus_write,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              acc_start,
    output logic [DATA_W-1:0] acc_cfg,
    input  logic              acc_done,
    input  logic [DATA_W-1:0] acc_result,
    output logic              irq
);
    localparam int MAW = $clog2(MEM_DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_BUSY   = 2'd2;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [1:0]        state;
    logic              irq_en, done_sticky;
    logic [DATA_W-1:0] cfg_q, result_q, cycle_cnt, scratch_q;
    logic [7:0]        err_cnt;

    logic       rd, wr, sel_sram, sel_mmio, unmapped;
    logic [2:0] off;
    logic [7:0] mmio_wr;
    logic       start_req, done_acc;

    // Decode: SRAM first, then the lower half of the 16-word MMIO window.
    assign rd       = bus_valid & ~bus_write;
    assign wr       = bus_valid & bus_write;
    assign sel_sram = (bus_addr < ADDR_W'(MEM_DEPTH));
    assign sel_mmio = ~sel_sram && (bus_addr[ADDR_W-1:4] == MMIO_BASE[ADDR_W-1:4])
                      && ~bus_addr[3];
    assign unmapped = bus_valid & ~sel_sram & ~sel_mmio;
    assign off      = bus_addr[2:0];

    always_comb begin
        mmio_wr = '0;
        if (wr && sel_mmio) mmio_wr[off] = 1'b1;
    end

    // Start is only honoured from IDLE; done only while a launch is in flight.
    assign start_req = mmio_wr[0] & bus_wdata[0] & (state == S_IDLE);
    assign done_acc  = acc_done & (state != S_IDLE);

    assign acc_start = (state == S_LAUNCH);
    assign acc_cfg   = cfg_q;

    always_ff @(posedge clk) begin
        if (wr && sel_sram) mem[bus_addr[MAW-1:0]] <= bus_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            irq_en      <= 1'b0;
            done_sticky <= 1'b0;
            cfg_q       <= '0;
            result_q    <= '0;
            cycle_cnt   <= '0;
            err_cnt     <= '0;
            scratch_q   <= '0;
            irq         <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            irq       <= done_sticky & irq_en;

            case (state)
                S_IDLE:   if (start_req) state <= S_LAUNCH;
                S_LAUNCH: state <= done_acc ? S_IDLE : S_BUSY;
                default:  if (done_acc) state <= S_IDLE;
            endcase

            if (mmio_wr[0]) irq_en    <= bus_wdata[1];
            if (mmio_wr[2]) cfg_q     <= bus_wdata;
            if (mmio_wr[6]) scratch_q <= bus_wdata;
            if (done_acc)   result_q  <= acc_result;

            // Completion beats both the launch-clear and the W1C.
            if (done_acc)                        done_sticky <= 1'b1;
            else if (start_req)                  done_sticky <= 1'b0;
            else if (mmio_wr[1] && bus_wdata[1]) done_sticky <= 1'b0;

            if (mmio_wr[5])                      err_cnt <= '0;
            else if (unmapped && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
        end
    end

    always_comb begin
        bus_rdata = '0;
        if (rd) begin
            if (sel_sram) begin
                bus_rdata = mem[bus_addr[MAW-1:0]];
            end else if (sel_mmio) begin
                case (off)
                    3'd0:    bus_rdata = {{(DATA_W-2){1'b0}}, irq_en, 1'b0};
                    3'd1:    bus_rdata = {{(DATA_W-2){1'b0}}, done_sticky, state != S_IDLE};
                    3'd2:    bus_rdata = cfg_q;
                    3'd3:    bus_rdata = result_q;
                    3'd4:    bus_rdata = cycle_cnt;
                    3'd5:    bus_rdata = {{(DATA_W-8){1'b0}}, err_cnt};
                    3'd6:    bus_rdata = scratch_q;
                    default: bus_rdata = ID_VALUE[DATA_W-1:0];
                endcase
            end
        end
    end
endmodule

// File: tb/tb_soc_bus_responder.sv
module tb_soc_bus_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_valid = 1'b0, bus_write = 1'b0;
    logic [18:0] bus_addr = '0, bus_wdata = '0, bus_rdata;
    logic        acc_start, irq;
    logic [18:0] acc_cfg;
    logic        acc_done = 1'b0;
    logic [18:0] acc_result = '0;
    logic        finished = 1'b0;

    soc_bus_responder dut (
        .clk(clk), .rst_n(rst_n),
        .bus_valid(bus_valid), .bus_write(bus_write),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .acc_start(acc_start), .acc_cfg(acc_cfg),
        .acc_done(acc_done), .acc_result(acc_result), .irq(irq)
    );

    always #5 clk = ~clk;

    localparam logic [18:0] CTRL = 19'h7FF00, STAT = 19'h7FF01, CFG = 19'h7FF02,
                            RES  = 19'h7FF03, CCNT = 19'h7FF04, ERR = 19'h7FF05,
                            SCR  = 19'h7FF06, ID   = 19'h7FF07;
    localparam int S_RDATA = 0, S_START = 1, S_IRQ = 2, S_CFG = 3;

    typedef struct {
        int          sel;
        logic [18:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0;

    logic [18:0] m_cc;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_cc <= '0;
        else        m_cc <= m_cc + 19'd1;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [18:0] act;
            e = q.pop_front();
            case (e.sel)
                S_RDATA: act = bus_rdata;
                S_START: act = {18'd0, acc_start};
                S_IRQ:   act = {18'd0, irq};
                default: act = acc_cfg;
            endcase
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #200000;
        if (!finished) begin
            bad++;
            $display("FAIL timeout: test did not complete");
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic cyc(input logic v, input logic w, input logic [18:0] a,
                       input logic [18:0] d = '0, input logic dn = 1'b0,
                       input logic [18:0] res = '0);
        @(posedge clk);
        #1;
        bus_valid = v; bus_write = w; bus_addr = a; bus_wdata = d;
        acc_done = dn; acc_result = res;
    endtask

    task automatic chk(input int sel, input logic [18:0] exp, input string name);
        exp_t e;
        e.sel = sel; e.exp = exp; e.name = name;
        q.push_back(e);
    endtask

    initial begin
        cyc(0, 0, '0);
        chk(S_START, 0, "rst_start"); chk(S_IRQ, 0, "rst_irq");
        chk(S_CFG, 0, "rst_cfg");     chk(S_RDATA, 0, "rst_rdata");
        cyc(0, 0, '0);
        #1;
        total++;
        if (acc_start !== 1'b0 || irq !== 1'b0 || acc_cfg !== '0 || bus_rdata !== '0) begin
            bad++;
            $display("FAIL rst_direct: start=%b irq=%b cfg=%h rdata=%h",
                     acc_start, irq, acc_cfg, bus_rdata);
        end
        rst_n = 1'b1;

        cyc(1, 0, ID);   chk(S_RDATA, 19'h50C01, "id");
        cyc(1, 0, CCNT); chk(S_RDATA, m_cc, "ccnt0");
        cyc(1, 0, CCNT); chk(S_RDATA, m_cc, "ccnt1");

        cyc(1, 1, 19'd5, 19'h12345);
        cyc(1, 0, 19'd5);    chk(S_RDATA, 19'h12345, "sram5");
        cyc(0, 0, 19'd5);    chk(S_RDATA, 0, "idle_rdata");
        cyc(1, 1, 19'd1023, 19'h7ABCD);
        cyc(1, 1, 19'd5, 19'h55555); chk(S_RDATA, 0, "wr_rdata");
        cyc(1, 0, 19'd1023); chk(S_RDATA, 19'h7ABCD, "sram1023");
        cyc(1, 0, 19'd1024); chk(S_RDATA, 0, "unmap1024");
        cyc(1, 0, ERR);      chk(S_RDATA, 1, "err_one");

        cyc(1, 1, CFG, 19'h1F0F0);
        cyc(1, 1, SCR, 19'h2AAAA); chk(S_CFG, 19'h1F0F0, "acc_cfg");
        cyc(1, 0, SCR); chk(S_RDATA, 19'h2AAAA, "scratch");
        cyc(1, 0, CFG); chk(S_RDATA, 19'h1F0F0, "cfg_rd");

        cyc(1, 1, CTRL, 19'd3); chk(S_START, 0, "start_early");
        cyc(1, 0, STAT); chk(S_START, 1, "start_pulse"); chk(S_RDATA, 1, "stat_launch");
        cyc(1, 0, STAT); chk(S_START, 0, "start_once");  chk(S_RDATA, 1, "stat_busy");
        cyc(1, 0, CTRL); chk(S_RDATA, 2, "ctrl_rd");
        cyc(0, 0, '0, '0, 1'b1, 19'h0ABCD);
        cyc(1, 0, RES);  chk(S_RDATA, 19'h0ABCD, "result"); chk(S_IRQ, 0, "irq_lag");
        cyc(1, 0, STAT); chk(S_RDATA, 2, "stat_done"); chk(S_IRQ, 1, "irq_set");
        cyc(1, 1, STAT, 19'd2);
        cyc(1, 0, STAT); chk(S_RDATA, 0, "stat_w1c"); chk(S_IRQ, 1, "irq_hold");
        cyc(0, 0, '0);   chk(S_IRQ, 0, "irq_fall");

        cyc(1, 1, CTRL, 19'd1);
        cyc(0, 0, '0);   chk(S_START, 1, "start2");
        cyc(1, 1, CTRL, 19'd3); chk(S_START, 0, "busy_nostart");
        cyc(1, 0, STAT); chk(S_START, 0, "no_second_start"); chk(S_RDATA, 1, "still_busy");
        cyc(1, 0, CTRL); chk(S_RDATA, 2, "irq_en_upd");
        cyc(1, 1, STAT, 19'd2, 1'b1, 19'h11111);
        cyc(1, 0, STAT); chk(S_RDATA, 2, "set_wins");
        cyc(0, 0, '0, '0, 1'b1, 19'h22222);
        cyc(1, 1, RES, 19'h0);
        cyc(1, 0, RES);  chk(S_RDATA, 19'h11111, "idle_done_ign");
        cyc(1, 0, STAT); chk(S_RDATA, 2, "stat_idle_done");

        cyc(1, 1, ERR, 19'h0);
        cyc(1, 0, 19'h7FF08); chk(S_RDATA, 0, "hole_rd");
        cyc(1, 0, ERR);       chk(S_RDATA, 1, "err_hole");
        for (int i = 0; i < 300; i++) begin
            cyc(1, i[0], 19'h40000, 19'h7FFFF);
            if (i == 10) chk(S_RDATA, 0, "unmap_rd");
        end
        cyc(1, 0, ERR); chk(S_RDATA, 255, "err_sat");
        cyc(1, 1, ERR, 19'h12);
        cyc(1, 0, ERR); chk(S_RDATA, 0, "err_clr");

        cyc(1, 1, CTRL, 19'd3);
        cyc(0, 0, '0);   chk(S_START, 1, "start3");
        cyc(1, 0, STAT);
        rst_n = 1'b0;
        chk(S_START, 0, "arst_start"); chk(S_IRQ, 0, "arst_irq");
        chk(S_CFG, 0, "arst_cfg");     chk(S_RDATA, 0, "arst_rdata");
        cyc(0, 0, '0);
        rst_n = 1'b1;
        cyc(0, 0, '0, '0, 1'b1, 19'h33333);
        cyc(1, 0, RES);  chk(S_RDATA, 0, "post_rst_result");
        cyc(1, 0, STAT); chk(S_RDATA, 0, "post_rst_stat");
        cyc(0, 0, '0);
        @(posedge clk);
        finished = 1'b1;
        if (bad != 0) $display("FAIL: %0d of %0d checks failed", bad, total);
        else          $display("PASS");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
